// File: rtl/mult_pkg.sv
// Shared types and constants for the mult_sched shared multiplier.
package mult_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_NREQ  = 2;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ADD,
        SHIFT,
        DONE
    } state_t;

    // Ceiling log2; clog2(1) == 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_datapath.sv
// Shift-add multiplier datapath: A/B/P/cnt registers with adder and shifters.
module mult_datapath
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic               i_add_en,
    input  logic               i_shift_en,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_b_lsb,
    output logic               o_b_zero,
    output logic               o_cnt_done,
    output logic [2*WIDTH-1:0] o_p
);

    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned CNTW = clog2(WIDTH + 1);

    logic [PW-1:0]    r_a;
    logic [PW-1:0]    r_p;
    logic [WIDTH-1:0] r_b;
    logic [CNTW-1:0]  r_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_p   <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_a   <= PW'(i_a);
            r_b   <= i_b;
            r_p   <= '0;
            r_cnt <= '0;
        end else begin
            if (i_add_en) begin
                r_p <= r_p + r_a;
            end
            if (i_shift_en) begin
                r_a   <= r_a << 1;
                r_b   <= r_b >> 1;
                r_cnt <= r_cnt + CNTW'(1);
            end
        end
    end

    assign o_b_lsb    = r_b[0];
    assign o_b_zero   = (r_b == '0);
    assign o_cnt_done = (r_cnt == CNTW'(WIDTH));
    assign o_p        = r_p;

endmodule

// File: rtl/mult_sched.sv
// Round-robin scheduler and FSM around one shared shift-add multiplier.
// Optional macro EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module mult_sched
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned NREQ  = DEF_NREQ,
    localparam int unsigned IDW  = (clog2(NREQ) > 1) ? clog2(NREQ) : 1
) (
    input  logic                  Clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] op_a,
    input  logic [NREQ*WIDTH-1:0] op_b,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  done,
    output logic [IDW-1:0]        done_id,
    output logic [2*WIDTH-1:0]    product
);

`ifdef EARLY_EXIT_EN
    localparam logic EARLY_EXIT = 1'b1;
`else
    localparam logic EARLY_EXIT = 1'b0;
`endif

    state_t             r_state;
    logic [IDW-1:0]     r_rr;
    logic [IDW-1:0]     r_id;

    logic               w_any;
    logic [IDW-1:0]     w_idx;
    logic [IDW-1:0]     w_rr_next;
    logic [NREQ-1:0]    w_onehot;
    logic [WIDTH-1:0]   w_a_sel;
    logic [WIDTH-1:0]   w_b_sel;
    logic               w_load;
    logic               w_add_en;
    logic               w_shift_en;
    logic               w_b_lsb;
    logic               w_b_zero;
    logic               w_cnt_done;
    logic               w_finish;
    logic [2*WIDTH-1:0] w_p;

    // First asserted request at or above the rr pointer, wrapping around.
    always_comb begin
        logic [IDW:0] v_sum;
        w_any = 1'b0;
        w_idx = '0;
        v_sum = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            v_sum = {1'b0, r_rr} + (IDW+1)'(i);
            if (v_sum >= (IDW+1)'(NREQ)) begin
                v_sum = v_sum - (IDW+1)'(NREQ);
            end
            if (!w_any && req[v_sum[IDW-1:0]]) begin
                w_any = 1'b1;
                w_idx = v_sum[IDW-1:0];
            end
        end
    end

    always_comb begin
        logic [IDW:0] v_next;
        v_next    = {1'b0, w_idx} + (IDW+1)'(1);
        w_rr_next = v_next[IDW-1:0];
        if (v_next >= (IDW+1)'(NREQ)) begin
            w_rr_next = '0;
        end
    end

    always_comb begin
        w_a_sel = '0;
        w_b_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_idx == IDW'(i)) begin
                w_a_sel = op_a[i*WIDTH +: WIDTH];
                w_b_sel = op_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_onehot   = NREQ'(1) << w_idx;
    assign w_load     = (r_state == IDLE) && w_any;
    assign w_add_en   = (r_state == ADD);
    assign w_shift_en = (r_state == SHIFT);
    assign w_finish   = w_cnt_done | (EARLY_EXIT & w_b_zero);

    mult_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .i_clk      (Clk),
        .i_reset    (reset),
        .i_load     (w_load),
        .i_add_en   (w_add_en),
        .i_shift_en (w_shift_en),
        .i_a        (w_a_sel),
        .i_b        (w_b_sel),
        .o_b_lsb    (w_b_lsb),
        .o_b_zero   (w_b_zero),
        .o_cnt_done (w_cnt_done),
        .o_p        (w_p)
    );

    // Control FSM; requests are only considered in IDLE.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_rr    <= '0;
            r_id    <= '0;
            gnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= '0;
            product <= '0;
        end else begin
            gnt  <= '0;
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= CHECK;
                        r_id    <= w_idx;
                        r_rr    <= w_rr_next;
                        gnt     <= w_onehot;
                        busy    <= 1'b1;
                    end
                end
                CHECK: begin
                    if (w_finish) begin
                        r_state <= DONE;
                        done    <= 1'b1;
                        done_id <= r_id;
                        product <= w_p;
                    end else if (w_b_lsb) begin
                        r_state <= ADD;
                    end else begin
                        r_state <= SHIFT;
                    end
                end
                ADD: begin
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    r_state <= CHECK;
                end
                DONE: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_sched.sv
// Scoreboard bench for mult_sched: grants, products, ids, latency, reset and arbitration.
module tb_mult_sched;

    localparam int unsigned W   = 8;
    localparam int unsigned N   = 2;
    localparam int unsigned IDW = 1;
    localparam int unsigned PW  = 2 * W;

    logic           Clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req;
    logic [N*W-1:0] op_a;
    logic [N*W-1:0] op_b;
    logic [N-1:0]   gnt;
    logic           busy;
    logic           done;
    logic [IDW-1:0] done_id;
    logic [PW-1:0]  product;

    mult_sched #(.WIDTH(W), .NREQ(N)) dut (
        .Clk     (Clk),
        .reset   (reset),
        .req     (req),
        .op_a    (op_a),
        .op_b    (op_b),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .product (product)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int            id;
        logic [PW-1:0] prod;
        int            due;
    } exp_t;

    exp_t          sb[$];
    int            exp_gnt[$];
    int            gnt_log[$];
    int            done_log[$];
    logic [W-1:0]  a_sh[N];
    logic [W-1:0]  b_sh[N];
    int            n_chk = 0;
    int            n_err = 0;
    int            n_gnt = 0;
    int            n_done = 0;
    bit            prev_done = 1'b0;
    logic          prev_busy = 1'b0;
    int            m_id;
    exp_t          m_e;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic [W-1:0] b);
        int iters;
        iters = W;
`ifdef EARLY_EXIT_EN
        iters = 0;
        for (int i = 0; i < W; i++) if (b[i]) iters = i + 1;
`endif
        return 2 * iters + $countones(b) + 2;
    endfunction

    // Output monitor: grants push expectations, dones pop and compare.
    always @(negedge Clk) begin
        if (!reset) begin
            if (prev_done) begin
                chk("busy_after_done", 64'(busy), 0);
                chk("gnt_after_done", 64'(gnt), 0);
            end
            if (gnt != '0) begin
                m_id = 0;
                for (int i = 0; i < N; i++) if (gnt[i]) m_id = i;
                chk("gnt_onehot", 64'($countones(gnt)), 1);
                chk("gnt_from_idle", 64'(prev_busy), 0);
                if (exp_gnt.size() > 0) chk("gnt_id", 64'(m_id), 64'(exp_gnt.pop_front()));
                m_e.id   = m_id;
                m_e.prod = PW'(a_sh[m_id]) * PW'(b_sh[m_id]);
                m_e.due  = cyc + exp_lat(b_sh[m_id]) - 1;
                sb.push_back(m_e);
                gnt_log.push_back(cyc);
                n_gnt++;
            end
            if (done) begin
                n_done++;
                done_log.push_back(cyc);
                if (sb.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    m_e = sb.pop_front();
                    chk("done_id", 64'(done_id), 64'(m_e.id));
                    chk("product", 64'(product), 64'(m_e.prod));
                    chk("latency", 64'(cyc), 64'(m_e.due));
                end
            end
            prev_done = done;
            prev_busy = busy;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic set_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        op_a[id*W +: W] = a;
        op_b[id*W +: W] = b;
        a_sh[id] = a;
        b_sh[id] = b;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_gnt", 64'(gnt), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_done_id", 64'(done_id), 0);
        chk("rst_product", 64'(product), 0);
        sb.delete();
        exp_gnt.delete();
        gnt_log.delete();
        done_log.delete();
        n_gnt = 0;
        n_done = 0;
        prev_done = 1'b0;
        prev_busy = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic wait_gnt(input int target);
        for (int k = 0; k < 200; k++) begin
            if (n_gnt >= target) return;
            tick(1);
        end
        chk("gnt_timeout", 64'(n_gnt), 64'(target));
    endtask

    task automatic wait_quiet();
        for (int k = 0; k < 400; k++) begin
            if (sb.size() == 0 && busy === 1'b0) return;
            tick(1);
        end
        chk("idle_timeout", 64'(sb.size()), 0);
    endtask

    task automatic single(input logic [W-1:0] a, input logic [W-1:0] b, input string tag, input int lat);
        int t0;
        do_reset();
        set_op(0, a, b);
        exp_gnt.push_back(0);
        t0 = cyc;
        req = 2'b01;
        wait_gnt(1);
        req = '0;
        wait_quiet();
        chk({tag, "_prod"}, 64'(product), 64'(PW'(a) * PW'(b)));
        if (gnt_log.size() > 0 && done_log.size() > 0) begin
            chk({tag, "_gnt_cyc"}, 64'(gnt_log[0]), 64'(t0 + 1));
            chk({tag, "_lat"}, 64'(done_log[0] - gnt_log[0] + 1), 64'(lat));
        end else begin
            chk({tag, "_events"}, 0, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0;
        req  = '0;
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < N; i++) begin
            a_sh[i] = '0;
            b_sh[i] = '0;
        end
        tick(1);

        // basic 3*5
        single(8'd3, 8'd5, "t1", 20);
        chk("t1_done_id", 64'(done_id), 0);

        // alternating requesters with req held
        do_reset();
        set_op(0, 8'd3, 8'd4);
        set_op(1, 8'd5, 8'd6);
        exp_gnt = '{0, 1, 0, 1};
        req = 2'b11;
        wait_gnt(4);
        req = '0;
        wait_quiet();
        chk("t2_ndone", 64'(n_done), 4);
        chk("t2_last_prod", 64'(product), 30);
        chk("t2_last_id", 64'(done_id), 1);

        // boundaries
        single(8'd255, 8'd255, "t3", 26);
`ifdef EARLY_EXIT_EN
        single(8'd9, 8'd0, "t4", 2);
        single(8'd7, 8'd5, "t4b", 10);
`else
        single(8'd9, 8'd0, "t4", 18);
        single(8'd7, 8'd5, "t4b", 20);
`endif
        single(8'd0, 8'd200, "t4c", exp_lat(8'd200));

        // reset mid-operation
        do_reset();
        set_op(0, 8'd200, 8'd201);
        exp_gnt.push_back(0);
        req = 2'b01;
        wait_gnt(1);
        req = '0;
        if (gnt_log.size() > 0) c0 = gnt_log[0];
        else c0 = cyc;
        while (cyc < c0 + 6) tick(1);
        do_reset();
        tick(30);
        chk("t5_no_done", 64'(n_done), 0);
        set_op(0, 8'd17, 8'd3);
        set_op(1, 8'd19, 8'd23);
        exp_gnt = '{0, 1};
        req = 2'b11;
        wait_gnt(2);
        req = '0;
        wait_quiet();
        chk("t5_ndone", 64'(n_done), 2);

        // requester 1 toggles while requester 0 is served
        do_reset();
        set_op(0, 8'd7, 8'd9);
        exp_gnt = '{0, 1};
        req = 2'b01;
        wait_gnt(1);
        req[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            req[1] = 1'($urandom);
            op_b[1*W +: W] = W'($urandom);
            tick(1);
        end
        chk("t6_no_early_gnt", 64'(n_gnt), 1);
        set_op(1, 8'd11, 8'd13);
        req = 2'b10;
        wait_gnt(2);
        req = '0;
        wait_quiet();
        if (gnt_log.size() > 1 && done_log.size() > 0)
            chk("t6_gap", 64'(gnt_log[1] - done_log[0]), 2);
        else
            chk("t6_events", 0, 1);
        chk("t6_prod", 64'(product), 143);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
